// File: rtl/core_control_fsm_if.sv
// -----------------------------------------------------------------------------
// core_control_fsm_if
//
// Instruction-bus and data-bus handshake bundle between the control sequencer
// and the memory side of the RV32I core.
//
// Handshake: each request is a level held high from the first cycle of the
// access until the rising edge on which the matching ack is sampled high. The
// ack is only meaningful while its request is high. A request never drops
// without an ack, except on reset or a timeout trap. data_we qualifies
// data_req (1 = store, 0 = load) and is stable for the whole request.
//
// Signals:
//   instr_req  master->slave  instruction fetch request
//   instr_ack  slave->master  fetch data valid this cycle
//   data_req   master->slave  data access request
//   data_we    master->slave  data access is a store
//   data_ack   slave->master  data access complete
// -----------------------------------------------------------------------------
interface core_control_fsm_if;
    logic instr_req;
    logic instr_ack;
    logic data_req;
    logic data_we;
    logic data_ack;

    // The sequencer issues requests; the memory side answers them.
    modport master (
        output instr_req,
        output data_req,
        output data_we,
        input  instr_ack,
        input  data_ack
    );

    modport slave (
        input  instr_req,
        input  data_req,
        input  data_we,
        output instr_ack,
        output data_ack
    );
endinterface

// File: rtl/core_control_fsm.sv
// -----------------------------------------------------------------------------
// core_control_fsm
//
// Multi-cycle control sequencer for the RV32I core. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. The sequencer drives the bus
// handshakes, the IR / register-file / PC write strobes and the PC source
// select. It also counts retired instructions, honours a debug halt request
// at instruction boundaries and traps on illegal instructions or on bus
// requests that wait too long for their ack.
//
// Parameters:
//   BUS_TIMEOUT     cycles a request may wait for its ack before a trap
//                   (0 disables the timeout)
//
// Ports:
//   clk             core clock, rising edge
//   rst_n           asynchronous active-low reset
//   bus             instruction/data handshake bundle (master side)
//   i_illegal       decoder found no valid instruction
//   i_data_r        decode flag: load
//   i_data_w        decode flag: store
//   i_reg_w         decode flag: writes rd
//   i_branch        decode flag: conditional branch
//   i_jump          decode flag: JAL
//   i_jalr          decode flag: JALR
//   i_branch_taken  branch comparison result (valid in EXEC and WB)
//   i_halt_req      debug halt request
//   o_ir_we         load instruction register
//   o_alu_en        ALU result register enable
//   o_reg_we        register-file write strobe
//   o_pc_we         PC update strobe
//   o_pc_sel        PC source: 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
//   o_halted        core stopped (HALT or TRAP)
//   o_trap          sticky trap flag
//   o_trap_cause    01 illegal, 10 fetch timeout, 11 data timeout
//   o_instret       retired-instruction counter
//   o_state         current FSM state, for debug
// -----------------------------------------------------------------------------
module core_control_fsm #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    core_control_fsm_if.master        bus,
    input  logic                      i_illegal,
    input  logic                      i_data_r,
    input  logic                      i_data_w,
    input  logic                      i_reg_w,
    input  logic                      i_branch,
    input  logic                      i_jump,
    input  logic                      i_jalr,
    input  logic                      i_branch_taken,
    input  logic                      i_halt_req,
    output logic                      o_ir_we,
    output logic                      o_alu_en,
    output logic                      o_reg_we,
    output logic                      o_pc_we,
    output logic [1:0]                o_pc_sel,
    output logic                      o_halted,
    output logic                      o_trap,
    output logic [1:0]                o_trap_cause,
    output logic [31:0]               o_instret,
    output logic [2:0]                o_state
);

    // Counter just wide enough to hold BUS_TIMEOUT.
    localparam int TO_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BUS_TIMEOUT);
    localparam bit TO_ENABLED = (BUS_TIMEOUT != 0);

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
    localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [TO_W-1:0]   r_wait_cnt;
    logic [TO_W-1:0]   w_wait_cnt_inc;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_set_trap;
    logic [1:0]        w_trap_cause;
    logic              r_trap;
    logic [1:0]        r_trap_cause;
    logic [31:0]       r_instret;

    // A cycle counts as waiting only while a request is out and unanswered.
    assign w_waiting      = ((r_state == ST_FETCH) && !bus.instr_ack) ||
                            ((r_state == ST_MEM)   && !bus.data_ack);
    assign w_wait_cnt_inc = r_wait_cnt + 1'b1;
    // The limit is judged on the count this cycle would produce, so the
    // BUS_TIMEOUT-th unanswered cycle is the last one. An ack in that same
    // cycle clears w_waiting and the access completes normally.
    assign w_timeout      = TO_ENABLED && w_waiting && (w_wait_cnt_inc == TO_LIMIT);

    // ------------------------------------------------------------------
    // State register and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RESET;
            r_wait_cnt   <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'b00;
            r_instret    <= 32'd0;
        end else begin
            r_state <= w_next_state;

            if (w_next_state != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= w_wait_cnt_inc;
            end

            // TRAP is only left through reset, so the flag and cause
            // simply latch on entry.
            if (w_set_trap) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_trap_cause;
            end

            // Retire on the edge that ends WB; wraps naturally at 2^32.
            if (r_state == ST_WB) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_set_trap   = 1'b0;
        w_trap_cause = 2'b00;

        case (r_state)
            ST_RESET: begin
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                if (bus.instr_ack) begin
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_TRAP;
                    w_set_trap   = 1'b1;
                    w_trap_cause = CAUSE_FETCH_TO;
                end
            end

            ST_DECODE: begin
                if (i_illegal) begin
                    w_next_state = ST_TRAP;
                    w_set_trap   = 1'b1;
                    w_trap_cause = CAUSE_ILLEGAL;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (i_data_r || i_data_w) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WB;
                end
            end

            ST_MEM: begin
                if (bus.data_ack) begin
                    w_next_state = ST_WB;
                end else if (w_timeout) begin
                    w_next_state = ST_TRAP;
                    w_set_trap   = 1'b1;
                    w_trap_cause = CAUSE_DATA_TO;
                end
            end

            // halt_req is looked at only here and in HALT, so an
            // instruction in flight always reaches retirement.
            ST_WB: begin
                if (i_halt_req) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_HALT: begin
                if (!i_halt_req) begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_TRAP: begin
                w_next_state = ST_TRAP;
            end

            default: begin
                w_next_state = ST_RESET;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Requests depend on state only; the write strobes
    // that must coincide with an ack or with WB are qualified here.
    // ------------------------------------------------------------------
    always_comb begin
        bus.instr_req = 1'b0;
        bus.data_req  = 1'b0;
        bus.data_we   = 1'b0;
        o_ir_we       = 1'b0;
        o_alu_en      = 1'b0;
        o_reg_we      = 1'b0;
        o_pc_we       = 1'b0;
        o_pc_sel      = PC_PLUS4;
        o_halted      = 1'b0;

        case (r_state)
            ST_FETCH: begin
                bus.instr_req = 1'b1;
                o_ir_we       = bus.instr_ack;
            end

            ST_EXEC: begin
                o_alu_en = 1'b1;
            end

            // A load+store flag combination is issued as a store.
            ST_MEM: begin
                bus.data_req = 1'b1;
                bus.data_we  = i_data_w;
            end

            ST_WB: begin
                o_reg_we = i_reg_w;
                o_pc_we  = 1'b1;
                if (i_jalr) begin
                    o_pc_sel = PC_JALR;
                end else if (i_jump || (i_branch && i_branch_taken)) begin
                    o_pc_sel = PC_REL;
                end else begin
                    o_pc_sel = PC_PLUS4;
                end
            end

            ST_HALT: begin
                o_halted = 1'b1;
            end

            ST_TRAP: begin
                o_halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

    assign o_trap       = r_trap;
    assign o_trap_cause = r_trap_cause;
    assign o_instret    = r_instret;
    assign o_state      = r_state;

endmodule

// File: tb/tb_core_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_core_control_fsm
//
// Directed and randomized bench for core_control_fsm. Every cycle the bench
// knows which phase of the instruction it is driving, derives the outputs the
// sequencer must show from the phase and the instruction's flags, and checks
// them half a cycle after the active edge.
// -----------------------------------------------------------------------------
module tb_core_control_fsm;

    localparam int TO = 16;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_TRAP   = 3'd7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_control_fsm_if bus();

    logic        illegal, data_r, data_w, reg_w, branch, jump, jalr;
    logic        branch_taken, halt_req;
    logic        ir_we, alu_en, reg_we, pc_we, halted, trap;
    logic [1:0]  pc_sel, trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    core_control_fsm #(.BUS_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .i_illegal      (illegal),
        .i_data_r       (data_r),
        .i_data_w       (data_w),
        .i_reg_w        (reg_w),
        .i_branch       (branch),
        .i_jump         (jump),
        .i_jalr         (jalr),
        .i_branch_taken (branch_taken),
        .i_halt_req     (halt_req),
        .o_ir_we        (ir_we),
        .o_alu_en       (alu_en),
        .o_reg_we       (reg_we),
        .o_pc_we        (pc_we),
        .o_pc_sel       (pc_sel),
        .o_halted       (halted),
        .o_trap         (trap),
        .o_trap_cause   (trap_cause),
        .o_instret      (instret),
        .o_state        (state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {instr_req, ir_we, alu_en, data_req, data_we, reg_we, pc_we, pc_sel, halted, trap, cause}
    function automatic logic [12:0] outs(input logic ireq, input logic irwe, input logic alu,
                                         input logic dreq, input logic dwe, input logic rwe,
                                         input logic pcwe, input logic [1:0] psel,
                                         input logic hlt, input logic trp, input logic [1:0] cause);
        return {ireq, irwe, alu, dreq, dwe, rwe, pcwe, psel, hlt, trp, cause};
    endfunction

    task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [12:0] exp_outs);
        logic [12:0] obs;
        obs = {bus.instr_req, ir_we, alu_en, bus.data_req, bus.data_we, reg_we, pc_we,
               pc_sel, halted, trap, trap_cause};
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " outputs"}, 32'(obs), 32'(exp_outs));
        check({tag, " instret"}, instret, exp_instret);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.instr_ack = 1'b0; bus.data_ack = 1'b0;
        illegal = 1'b0; data_r = 1'b0; data_w = 1'b0; reg_w = 1'b0;
        branch = 1'b0; jump = 1'b0; jalr = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    endtask

    // Ends half a cycle into the RESET cycle that follows rst_n release.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        exp_instret = 32'd0;
        #1 expect_cycle("reset_held", S_RESET, 13'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 expect_cycle("reset_release", S_RESET, 13'd0);
    endtask

    // One complete legal instruction. wi / wd are wait states before the ack.
    // halt_wb raises halt_req from EXEC on; the core then stays in HALT for
    // halt_cycles cycles before halt_req is dropped.
    task automatic run_instr(input bit rd, input bit wr, input bit rw, input bit br,
                             input bit tk, input bit jp, input bit jr,
                             input int wi, input int wd, input bit halt_wb,
                             input int halt_cycles);
        logic [1:0] sel;
        sel = jr ? 2'b10 : ((jp || (br && tk)) ? 2'b01 : 2'b00);
        for (int c = 0; c <= wi; c++) begin
            @(negedge clk);
            data_r = rd; data_w = wr; reg_w = rw; branch = br; jump = jp; jalr = jr;
            illegal = 1'b0;
            bus.instr_ack = (c == wi);
            halt_req = 1'($urandom_range(0, 1));
            #1 expect_cycle("fetch", S_FETCH, outs(1, c == wi, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        end
        @(negedge clk);
        bus.instr_ack = 1'b0;
        halt_req = 1'($urandom_range(0, 1));
        #1 expect_cycle("decode", S_DECODE, 13'd0);
        @(negedge clk);
        branch_taken = tk;
        halt_req = halt_wb ? 1'b1 : 1'($urandom_range(0, 1));
        #1 expect_cycle("exec", S_EXEC, outs(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        if (rd || wr) begin
            for (int c = 0; c <= wd; c++) begin
                @(negedge clk);
                bus.data_ack = (c == wd);
                halt_req = halt_wb ? 1'b1 : 1'($urandom_range(0, 1));
                #1 expect_cycle("mem", S_MEM, outs(0, 0, 0, 1, wr, 0, 0, 2'b00, 0, 0, 2'b00));
            end
        end
        @(negedge clk);
        bus.data_ack = 1'b0;
        halt_req = halt_wb;
        #1 expect_cycle("wb", S_WB, outs(0, 0, 0, 0, 0, rw, 1, sel, 0, 0, 2'b00));
        exp_instret = exp_instret + 32'd1;
        if (halt_wb) begin
            for (int h = 0; h < halt_cycles; h++) begin
                @(negedge clk);
                halt_req = (h < halt_cycles - 1);
                #1 expect_cycle("halt", S_HALT, outs(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00));
            end
        end
    endtask

    // Fetch, decode and execute a memory instruction; stops after checking
    // the first MEM cycle (no data ack yet).
    task automatic run_to_mem(input bit rd, input bit wr);
        @(negedge clk);
        data_r = rd; data_w = wr; reg_w = rd; illegal = 1'b0;
        bus.instr_ack = 1'b1;
        #1 expect_cycle("to_mem fetch", S_FETCH, outs(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        @(negedge clk);
        bus.instr_ack = 1'b0;
        #1 expect_cycle("to_mem decode", S_DECODE, 13'd0);
        @(negedge clk);
        #1 expect_cycle("to_mem exec", S_EXEC, outs(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        @(negedge clk);
        bus.data_ack = 1'b0;
        #1 expect_cycle("to_mem mem", S_MEM, outs(0, 0, 0, 1, wr, 0, 0, 2'b00, 0, 0, 2'b00));
    endtask

    // TRAP must hold regardless of acks or halt_req.
    task automatic expect_trap(input string tag, input logic [1:0] cause, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            bus.instr_ack = 1'($urandom_range(0, 1));
            bus.data_ack = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1));
            #1 expect_cycle(tag, S_TRAP, outs(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, cause));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        do_reset();

        // Straight-line ALU: three ADDs, 4 cycles each.
        for (int i = 0; i < 3; i++) run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load with two data wait states.
        run_instr(1, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
        // Store, and a load+store combination issued as a store.
        run_instr(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_instr(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);

        // Taken branch, then JALR, then JAL, then untaken branch.
        run_instr(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_instr(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Halt raised during EXEC: retire, stay halted, then resume.
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3);
        run_instr(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);

        // Acks arriving in the cycle the wait count reaches its limit win.
        run_instr(1, 0, 1, 0, 0, 0, 0, TO - 1, TO - 1, 0, 0);

        // Randomized instruction mix.
        for (int i = 0; i < 40; i++) begin
            run_instr(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                      $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                      $urandom_range(1, 3));
        end

        // Retired-instruction counter wrap via backdoor preload.
        do_reset();
        force dut.r_instret = 32'hFFFF_FFFF;
        #1 release dut.r_instret;
        exp_instret = 32'hFFFF_FFFF;
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.instr_ack = 1'b0;
        #1 check("instret_wrap", instret, 32'd0);

        // Reset in the middle of a data access.
        do_reset();
        run_to_mem(1, 0);
        rst_n = 1'b0;
        exp_instret = 32'd0;
        #1 expect_cycle("mid_mem_reset", S_RESET, 13'd0);

        // Illegal instruction trap.
        do_reset();
        @(negedge clk);
        bus.instr_ack = 1'b1;
        #1 expect_cycle("ill fetch", S_FETCH, outs(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        @(negedge clk);
        bus.instr_ack = 1'b0;
        illegal = 1'b1;
        #1 expect_cycle("ill decode", S_DECODE, 13'd0);
        expect_trap("trap_illegal", 2'b01, 20);

        // Fetch timeout: instr_ack never arrives.
        do_reset();
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            bus.instr_ack = 1'b0;
            #1 expect_cycle("fetch_wait", S_FETCH, outs(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
        end
        expect_trap("trap_fetch_to", 2'b10, 3);

        // Data timeout: data_ack never arrives.
        do_reset();
        run_to_mem(0, 1);
        for (int c = 1; c < TO; c++) begin
            @(negedge clk);
            bus.data_ack = 1'b0;
            #1 expect_cycle("mem_wait", S_MEM, outs(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 2'b00));
        end
        expect_trap("trap_data_to", 2'b11, 3);

        // Reset leaves TRAP and restarts fetching.
        do_reset();
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
